key_scheduler_multimode_shifter: RTL and testbench

Runtime-selectable AES key expansion for AES-128/192/256. It computes all round keys sequentially, `N_WORDS` words per enabled cycle, and presents them as one flat round-key vector to the cipher datapath. It replaces the fixed-mode sequential key scheduler in front of the AES round pipeline that feeds the GHASH/GCM core, and adds mode selection, a busy/ready handshake and an error flag.

---
 rtl/key_scheduler_multimode_shifter_pkg.sv | 85 ++++++++
 rtl/key_scheduler_multimode_nwords.sv | 50 +++++
 rtl/key_scheduler_multimode_shifter.sv | 175 +++++++++++++++++
 tb/tb_key_scheduler_multimode_shifter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_scheduler_multimode_shifter_pkg.sv
// Shared definitions for the multimode AES key scheduler.
//   - mode encodings, scheduler FSM state type, word-storage depth
//   - Nk / Nr / total-word lookups per mode
//   - GF(2^8) helpers (xtime, multiply) and the AES S-box
//   - RotWord / SubWord helpers used by the batch generator
package aes_key_pkg;

  localparam logic [1:0] MODE_AES128 = 2'd0;
  localparam logic [1:0] MODE_AES192 = 2'd1;
  localparam logic [1:0] MODE_AES256 = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // Largest key schedule (AES-256) holds 60 words.
  localparam int WORDS_MAX = 60;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      MODE_AES128: nk_of = 4'd4;
      MODE_AES192: nk_of = 4'd6;
      default:     nk_of = 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      MODE_AES128: nr_of = 4'd10;
      MODE_AES192: nr_of = 4'd12;
      default:     nr_of = 4'd14;
    endcase
  endfunction

  // T = 4 * (Nr + 1)
  function automatic logic [6:0] total_words_of(input logic [1:0] mode);
    case (mode)
      MODE_AES128: total_words_of = 7'd44;
      MODE_AES192: total_words_of = 7'd52;
      default:     total_words_of = 7'd60;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by
  // the AES affine transform, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] expo;
    expo = 8'hfe;
    inv  = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (expo[i]) inv = gf_mul(inv, x);
    end
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_scheduler_multimode_nwords.sv
// Combinational batch generator: produces key words w[idx .. idx+N_WORDS-1].
//   prev_words_i[j] : w[idx - Nk + j]  (the w[i-Nk] term of each output word)
//   last_word_i     : w[idx - 1]       (seeds the w[i-1] chain)
//   idx_i, nk_i     : index of first word in the batch, key length in words
//   rcon_i          : round constant for the next mod-Nk=0 word
//   words_o         : the N_WORDS new words, lowest index first
//   rcon_used_o     : a mod-Nk=0 word was in this batch (rcon must advance)
// Only N_WORDS of the previous Nk words are needed because N_WORDS <= Nk.
module key_scheduler_multimode_nwords
  import aes_key_pkg::*;
#(
  parameter int N_WORDS = 4
) (
  input  logic [31:0] prev_words_i [N_WORDS],
  input  logic [31:0] last_word_i,
  input  logic [5:0]  idx_i,
  input  logic [3:0]  nk_i,
  input  logic [7:0]  rcon_i,
  output logic [31:0] words_o [N_WORDS],
  output logic        rcon_used_o
);

  logic [31:0] chain;
  logic [31:0] temp;
  logic [6:0]  word_idx;
  logic [6:0]  word_mod;

  always_comb begin
    rcon_used_o = 1'b0;
    chain       = last_word_i;
    temp        = '0;
    word_idx    = '0;
    word_mod    = '0;
    for (int j = 0; j < N_WORDS; j++) begin
      word_idx = 7'(idx_i) + 7'(j);
      word_mod = word_idx % 7'(nk_i);
      temp     = chain;
      if (word_mod == 7'd0) begin
        temp        = sub_word(rot_word(chain)) ^ {rcon_i, 24'h000000};
        rcon_used_o = 1'b1;
      end else if (nk_i == 4'd8 && word_mod == 7'd4) begin
        temp = sub_word(chain);
      end
      words_o[j] = prev_words_i[j] ^ temp;
      // Later words in the batch chain off this one, not off storage.
      chain = words_o[j];
    end
  end

endmodule

// File: rtl/key_scheduler_multimode_shifter.sv
// Runtime-selectable AES-128/192/256 key expansion, N_WORDS words per
// enabled cycle, presented as a flat 15 x 128-bit round-key vector.
//   i_clock, i_reset_n   : rising-edge clock, async active-low reset
//   i_valid              : clock enable; low freezes all state (pulses still clear)
//   i_start, i_key_mode  : start request and mode (0/1/2, 3 rejected)
//   i_key                : MSB-aligned cipher key
//   o_round_key_vector   : round key r at [r*128 +: 128], word 4r in the MSBs
//   o_n_rounds           : Nr of the latched mode
//   o_busy               : expansion in progress
//   o_output_ready       : one-cycle pulse after the final batch is written
//   o_error              : one-cycle pulse after a reserved-mode start
//   o_dbg_state          : FSM state
// Handshake: a start is accepted on a rising edge with i_valid & i_start while
// idle; o_busy is high from the next cycle until the edge writing the last
// batch, which also raises o_output_ready for exactly one cycle. Starts seen
// while busy are dropped silently.
module key_scheduler_multimode_shifter
  import aes_key_pkg::*;
#(
  parameter int NB_BYTE         = 8,
  parameter int N_BYTES_STATE   = 16,
  parameter int N_BYTES_KEY_MAX = 32,
  parameter int N_ROUNDS_MAX    = 14,
  parameter int N_WORDS         = 4
) (
  input  logic                                             i_clock,
  input  logic                                             i_reset_n,
  input  logic                                             i_valid,
  input  logic                                             i_start,
  input  logic [1:0]                                       i_key_mode,
  input  logic [N_BYTES_KEY_MAX*NB_BYTE-1:0]               i_key,
  output logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1)-1:0] o_round_key_vector,
  output logic [3:0]                                       o_n_rounds,
  output logic                                             o_busy,
  output logic                                             o_output_ready,
  output logic                                             o_error,
  output ks_state_e                                        o_dbg_state
);

  localparam int KEY_W   = N_BYTES_KEY_MAX * NB_BYTE;
  localparam int RK_W    = N_BYTES_STATE * NB_BYTE;
  localparam int N_STORE = WORDS_MAX;

  ks_state_e   state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  nr_q, nr_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] w_q [N_STORE];
  logic [31:0] w_d [N_STORE];

  logic [3:0]  nk, nk_new;
  logic [6:0]  t_words, t_new;
  logic [6:0]  rd_idx, last_idx, wr_idx;
  logic [31:0] prev_words [N_WORDS];
  logic [31:0] last_word;
  logic [31:0] batch [N_WORDS];
  logic        rcon_used;

  assign nk      = nk_of(mode_q);
  assign t_words = total_words_of(mode_q);
  assign nk_new  = nk_of(i_key_mode);
  assign t_new   = total_words_of(i_key_mode);

  // Storage reads feeding the batch generator.
  always_comb begin
    rd_idx   = '0;
    last_idx = 7'(idx_q) - 7'd1;
    for (int k = 0; k < N_WORDS; k++) begin
      rd_idx        = 7'(idx_q) + 7'(k) - 7'(nk);
      prev_words[k] = (rd_idx < 7'(N_STORE)) ? w_q[rd_idx[5:0]] : '0;
    end
    last_word = (idx_q != 6'd0 && last_idx < 7'(N_STORE)) ? w_q[last_idx[5:0]] : '0;
  end

  key_scheduler_multimode_nwords #(
    .N_WORDS (N_WORDS)
  ) u_nwords (
    .prev_words_i (prev_words),
    .last_word_i  (last_word),
    .idx_i        (idx_q),
    .nk_i         (nk),
    .rcon_i       (rcon_q),
    .words_o      (batch),
    .rcon_used_o  (rcon_used)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    nr_d    = nr_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    w_d     = w_q;
    wr_idx  = '0;
    if (i_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (i_key_mode == MODE_RSVD) begin
              error_d = 1'b1;
            end else begin
              mode_d  = i_key_mode;
              nr_d    = nr_of(i_key_mode);
              idx_d   = 6'(nk_new);
              rcon_d  = 8'h01;
              state_d = ST_RUN;
              for (int i = 0; i < 8; i++) begin
                if (4'(i) < nk_new) w_d[i] = i_key[KEY_W-1-32*i -: 32];
              end
              // Rounds beyond Nr must read as zero.
              for (int i = 0; i < N_STORE; i++) begin
                if (7'(i) >= t_new) w_d[i] = '0;
              end
            end
          end
        end
        ST_RUN: begin
          // Words past T (AES-192 with 4-word batches) are dropped.
          for (int j = 0; j < N_WORDS; j++) begin
            wr_idx = 7'(idx_q) + 7'(j);
            if (wr_idx < t_words) w_d[wr_idx[5:0]] = batch[j];
          end
          if (rcon_used) rcon_d = xtime(rcon_q);
          idx_d = idx_q + 6'(N_WORDS);
          if (7'(idx_q) + 7'(N_WORDS) >= t_words) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_AES128;
      nr_q    <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      for (int i = 0; i < N_STORE; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      nr_q    <= nr_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      ready_q <= ready_d;
      error_q <= error_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    o_round_key_vector = '0;
    for (int r = 0; r <= N_ROUNDS_MAX; r++) begin
      o_round_key_vector[r*RK_W +: RK_W] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
    end
  end

  assign o_n_rounds     = nr_q;
  assign o_busy         = (state_q == ST_RUN);
  assign o_output_ready = ready_q;
  assign o_error        = error_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_key_scheduler_multimode_shifter.sv
module tb_key_scheduler_multimode_shifter;
  import aes_key_pkg::*;

  localparam int N_WORDS = 4;
  localparam int VEC_W   = 128 * 15;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       key_mode = 2'd0;
  logic [255:0]     key = '0;
  logic [VEC_W-1:0] rk_vec;
  logic [3:0]       n_rounds;
  logic             busy;
  logic             out_ready;
  logic             err;
  ks_state_e        dbg_state;

  always #5 clk = ~clk;

  key_scheduler_multimode_shifter #(
    .NB_BYTE         (8),
    .N_BYTES_STATE   (16),
    .N_BYTES_KEY_MAX (32),
    .N_ROUNDS_MAX    (14),
    .N_WORDS         (N_WORDS)
  ) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_valid            (valid),
    .i_start            (start),
    .i_key_mode         (key_mode),
    .i_key              (key),
    .o_round_key_vector (rk_vec),
    .o_n_rounds         (n_rounds),
    .o_busy             (busy),
    .o_output_ready     (out_ready),
    .o_error            (err),
    .o_dbg_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_fail = 0;
  logic [127:0]     exp_q[$];
  logic [VEC_W-1:0] last_vec = '0;
  logic [7:0]       sbox_t [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box by brute-force inverse search plus bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int b = 0; b < 8; b++) begin
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      end
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] tb_subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] mode, input logic [255:0] k,
                              output logic [VEC_W-1:0] vec);
    int          nk;
    int          total;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk    = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 6 : 8;
    total = 4 * (nk + 7);
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = tb_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end else if (nk == 8 && i % 8 == 4) begin
        t = tb_subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) vec[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 15; r++) check($sformatf("%s_round%0d", tag, r), rk_vec[r*128 +: 128], '0);
    check({tag, "_n_rounds"}, 128'(n_rounds), '0);
    check({tag, "_busy"}, 128'(busy), '0);
    check({tag, "_ready"}, 128'(out_ready), '0);
    check({tag, "_error"}, 128'(err), '0);
  endtask

  task automatic run_mode(input string tag, input logic [1:0] mode, input logic [255:0] k,
                          input int exp_cycles, input bit toggle, input int restart_at);
    logic [VEC_W-1:0] mv;
    logic [127:0]     e;
    int               cycles;
    bit               seen;
    model_expand(mode, k, mv);
    for (int r = 0; r < 15; r++) exp_q.push_back(mv[r*128 +: 128]);
    @(negedge clk);
    valid = 1'b1; start = 1'b1; key_mode = mode; key = k;
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
    key_mode = 2'($urandom_range(0, 3));
    check({tag, "_busy_after_start"}, 128'(busy), 128'd1);
    cycles = 0; seen = 1'b0;
    while (cycles < exp_cycles + 10 && !seen) begin
      if (out_ready) begin
        seen = 1'b1;
      end else begin
        if (toggle) valid = ~valid;
        start = (cycles == restart_at);
        if (cycles == restart_at) key_mode = 2'd0;
        @(negedge clk);
        cycles++;
      end
    end
    start = 1'b0;
    check({tag, "_ready_latency"}, 128'(cycles), 128'(exp_cycles));
    check({tag, "_n_rounds"}, 128'(n_rounds), 128'(10 + 2 * int'(mode)));
    check({tag, "_busy_at_ready"}, 128'(busy), '0);
    for (int r = 0; r < 15; r++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_round%0d", tag, r), rk_vec[r*128 +: 128], e);
    end
    last_vec = mv;
    valid = 1'b1;
    @(negedge clk);
    check({tag, "_ready_single_pulse"}, 128'(out_ready), '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    build_sbox();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 128'(dbg_state), 128'(ST_IDLE));
    rst_n = 1'b1;

    run_mode("aes128", 2'd0, 256'h2b7e151628aed2a6abf7158809cf4f3c << 128, 10, 1'b0, -1);
    check("aes128_fips_r1", rk_vec[1*128 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_fips_r10", rk_vec[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("aes128_r11_zero", rk_vec[11*128 +: 128], '0);

    run_mode("aes192", 2'd1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b << 64, 12, 1'b0, -1);
    check("aes192_fips_r12", rk_vec[12*128 +: 128], 128'he98ba06f448c773c8ecc720401002202);

    run_mode("aes256", 2'd2,
             256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 13, 1'b0, -1);
    check("aes256_fips_r14", rk_vec[14*128 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);

    run_mode("aes256_stall", 2'd2,
             256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 26, 1'b1, 5);

    // Reserved mode: single error pulse, nothing else moves.
    @(negedge clk);
    valid = 1'b1; start = 1'b1; key_mode = 2'd3; key = {8{$urandom()}};
    @(negedge clk);
    start = 1'b0;
    check("rsvd_error_pulse", 128'(err), 128'd1);
    check("rsvd_busy", 128'(busy), '0);
    @(negedge clk);
    check("rsvd_error_clears", 128'(err), '0);
    for (int r = 0; r < 15; r++)
      check($sformatf("rsvd_keep_round%0d", r), rk_vec[r*128 +: 128], last_vec[r*128 +: 128]);

    // Reset in the middle of a run discards everything.
    valid = 1'b1; start = 1'b1; key_mode = 2'd0; key = {8{$urandom()}};
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_mode("aes128_after_reset", 2'd0,
             {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0}, 10, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
